// File: rtl/cnn_layer_seq.sv
// Sequencer for one Conv1d+MaxPool layer: loads biases/taps from a 1-cycle ROM, then streams samples and counts pooled outputs.
// Each weight beat takes at least 3 cycles (RD, WAIT, SEND). Every layer strobe holds its data until i_ack.
module cnn_layer_seq #(
    parameter int DW        = 32,
    parameter int IN_CH     = 1,
    parameter int OUT_CH    = 2,
    parameter int SIZE_K    = 3,
    parameter int N_SAMPLES = 16,
    parameter int N_OUT     = 7,
    parameter int AW        = 8
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [AW-1:0]         o_w_addr,
    output logic                  o_w_rd,
    input  logic [DW*IN_CH-1:0]   i_w_data,
    input  logic [DW*IN_CH-1:0]   i_x_data,
    input  logic                  i_x_valid,
    output logic                  o_x_ready,
    output logic                  o_EN_w,
    output logic                  o_EN_c,
    input  logic                  i_layer_busy,
    output logic [DW*IN_CH-1:0]   o_data,
    output logic                  o_stb,
    input  logic                  i_ack,
    input  logic                  i_y_stb,
    input  logic                  i_y_ack
);

    localparam int NB = OUT_CH / IN_CH + SIZE_K * OUT_CH;
    localparam int SW = $clog2(N_SAMPLES) + 1;
    localparam int GW = $clog2(N_OUT) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NB - 1);
    localparam logic [SW-1:0] SENT_MAX  = SW'(N_SAMPLES);
    localparam logic [GW-1:0] GOT_MAX   = GW'(N_OUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WEN,
        S_RD,
        S_WAIT,
        S_SEND,
        S_CEN,
        S_RUN,
        S_FIN
    } state_t;

    state_t               state;
    logic [AW-1:0]        addr;
    logic [SW-1:0]        sent;
    logic [GW-1:0]        got;
    logic [DW*IN_CH-1:0]  w_dat;
    logic                 w_stb;

    logic run;
    logic x_stb;
    logic y_hs;

    // In RUN the layer port is a straight pass-through of the sample stream.
    assign run       = (state == S_RUN);
    assign x_stb     = i_x_valid && (sent < SENT_MAX);
    assign o_stb     = run ? x_stb : w_stb;
    assign o_data    = run ? i_x_data : w_dat;
    assign o_x_ready = run && x_stb && i_ack;
    assign y_hs      = run && i_y_stb && i_y_ack;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            addr     <= '0;
            sent     <= '0;
            got      <= '0;
            w_dat    <= '0;
            w_stb    <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_w_addr <= '0;
            o_w_rd   <= 1'b0;
            o_EN_w   <= 1'b0;
            o_EN_c   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state  <= S_WEN;
                        addr   <= '0;
                        sent   <= '0;
                        got    <= '0;
                        o_busy <= 1'b1;
                        o_EN_w <= 1'b1;
                    end
                end
                S_WEN: begin
                    o_EN_w   <= 1'b0;
                    o_w_rd   <= 1'b1;
                    o_w_addr <= addr;
                    state    <= S_RD;
                end
                S_RD: begin
                    o_w_rd <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    w_dat <= i_w_data;
                    w_stb <= 1'b1;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (w_stb && i_ack) begin
                        w_stb <= 1'b0;
                        if (addr == LAST_ADDR) begin
                            state <= S_CEN;
                        end else begin
                            addr     <= addr + 1'b1;
                            o_w_addr <= addr + 1'b1;
                            o_w_rd   <= 1'b1;
                            state    <= S_RD;
                        end
                    end
                end
                S_CEN: begin
                    if (!i_layer_busy) begin
                        o_EN_c <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (o_x_ready) begin
                        sent <= sent + 1'b1;
                    end
                    // got saturates so late handshakes cannot push it past the exit condition
                    if (y_hs && (got < GOT_MAX)) begin
                        got <= got + 1'b1;
                    end
                    if ((got == GOT_MAX) && (sent == SENT_MAX)) begin
                        o_EN_c <= 1'b0;
                        state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    // done is raised for the last FIN cycle so it overlaps o_busy
                    if (o_done) begin
                        o_done <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else if (!i_layer_busy) begin
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    a_done_in_busy: assert property (@(posedge clk) disable iff (!RSTn)
        o_done |-> o_busy);

    a_weight_hold: assert property (@(posedge clk) disable iff (!RSTn)
        (state == S_SEND && o_stb && !i_ack) |=> (o_stb && $stable(o_data)));

    a_no_stb_idle: assert property (@(posedge clk) disable iff (!RSTn)
        (state == S_IDLE) |-> !o_stb);

    a_enw_rd_excl: assert property (@(posedge clk) disable iff (!RSTn)
        !(o_EN_w && o_w_rd));

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq: reset, weight load with a stalled beat, table-driven compute phase, restart.
module tb_cnn_layer_seq;

    logic        clk = 1'b0;
    logic        RSTn;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_w_addr;
    logic        o_w_rd;
    logic [31:0] i_w_data;
    logic [31:0] i_x_data;
    logic        i_x_valid;
    logic        o_x_ready;
    logic        o_EN_w;
    logic        o_EN_c;
    logic        i_layer_busy;
    logic [31:0] o_data;
    logic        o_stb;
    logic        i_ack;
    logic        i_y_stb;
    logic        i_y_ack;

    always #5 clk = ~clk;

    cnn_layer_seq dut (
        .clk          (clk),
        .RSTn         (RSTn),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_w_addr     (o_w_addr),
        .o_w_rd       (o_w_rd),
        .i_w_data     (i_w_data),
        .i_x_data     (i_x_data),
        .i_x_valid    (i_x_valid),
        .o_x_ready    (o_x_ready),
        .o_EN_w       (o_EN_w),
        .o_EN_c       (o_EN_c),
        .i_layer_busy (i_layer_busy),
        .o_data       (o_data),
        .o_stb        (o_stb),
        .i_ack        (i_ack),
        .i_y_stb      (i_y_stb),
        .i_y_ack      (i_y_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // layer/ROM model and monitors
    int          slow_beat;
    int          stb_age;
    int          n_wxfer, n_wrd, n_enw, n_xrdy, n_done, n_hold103;
    logic        done_busy;
    logic [31:0] wq[$];
    logic [31:0] xq[$];
    logic        rd_pend;
    logic [31:0] rom_nxt;
    logic        prev_hold;
    logic [31:0] prev_dat;

    task automatic clear_mon();
        n_wxfer = 0; n_wrd = 0; n_enw = 0; n_xrdy = 0; n_done = 0; n_hold103 = 0;
        done_busy = 1'b0;
        wq.delete(); xq.delete();
        rd_pend = 1'b0; stb_age = 0; prev_hold = 1'b0; prev_dat = '0;
        i_ack = 1'b0;
    endtask

    // Called just after a falling edge once inputs are set; decides i_ack and observes this cycle.
    task automatic eval();
        int cur_dly;
        i_w_data = rd_pend ? rom_nxt : 32'hBAD0_BAD0;
        #1;
        cur_dly = o_EN_c ? 0 : ((slow_beat == n_wxfer) ? 5 : 1);
        i_ack = o_stb && (stb_age >= cur_dly);
        #1;
        if (o_stb && !o_EN_c && prev_hold) chk("wdata_hold", o_data, prev_dat);
        if (o_stb && !i_ack && o_data == 32'd103) n_hold103++;
        if (o_stb && i_ack && !o_EN_c) begin
            wq.push_back(o_data);
            n_wxfer++;
        end
        if (o_w_rd) begin
            chk("rd_addr", 32'(o_w_addr), n_wrd);
            n_wrd++;
        end
        rd_pend = o_w_rd;
        rom_nxt = 32'(o_w_addr) + 32'd100;
        if (o_EN_w) n_enw++;
        if (o_x_ready) begin
            n_xrdy++;
            xq.push_back(o_data);
        end
        if (o_done) begin
            n_done++;
            done_busy = o_busy;
        end
        prev_hold = o_stb && !i_ack;
        prev_dat  = o_data;
        stb_age   = (o_stb && !i_ack) ? stb_age + 1 : 0;
    endtask

    task automatic cyc();
        eval();
        @(negedge clk);
    endtask

    task automatic check_weights(input string tag);
        chk({tag, "_nxfer"}, n_wxfer, 8);
        chk({tag, "_nrd"}, n_wrd, 8);
        chk({tag, "_nenw"}, n_enw, 1);
        for (int k = 0; k < 8; k++) begin
            if (k < wq.size()) chk({tag, "_wdata"}, wq[k], 32'(100 + k));
        end
    endtask

    typedef struct {
        logic        xv;
        logic [31:0] xd;
        logic        ys;
        logic        ya;
        logic        exp_rdy;
        logic        exp_enc;
    } vec_t;

    vec_t tv[22];

    task automatic row(input int i, input logic xv, input int xd, input logic ys, input logic ya,
                       input logic er, input logic ee);
        tv[i].xv = xv; tv[i].xd = 32'(xd); tv[i].ys = ys; tv[i].ya = ya;
        tv[i].exp_rdy = er; tv[i].exp_enc = ee;
    endtask

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Compute-phase vectors: gaps, a y_stb without y_ack, simultaneous handshakes,
        // two extra handshakes after got reaches 7, then a 17th valid sample.
        row(0,  1, 1,  0, 0, 1, 1);
        row(1,  1, 2,  0, 0, 1, 1);
        row(2,  0, 0,  0, 0, 0, 1);
        row(3,  1, 3,  1, 1, 1, 1);
        row(4,  1, 4,  1, 0, 1, 1);
        row(5,  0, 0,  1, 1, 0, 1);
        row(6,  1, 5,  0, 0, 1, 1);
        row(7,  1, 6,  0, 0, 1, 1);
        row(8,  1, 7,  1, 1, 1, 1);
        row(9,  0, 0,  0, 0, 0, 1);
        row(10, 1, 8,  0, 0, 1, 1);
        row(11, 1, 9,  1, 1, 1, 1);
        row(12, 1, 10, 0, 0, 1, 1);
        row(13, 1, 11, 0, 0, 1, 1);
        row(14, 0, 0,  1, 1, 0, 1);
        row(15, 1, 12, 0, 0, 1, 1);
        row(16, 1, 13, 1, 1, 1, 1);
        row(17, 1, 14, 1, 1, 1, 1);
        row(18, 1, 15, 1, 1, 1, 1);
        row(19, 1, 16, 1, 1, 1, 1);
        row(20, 1, 17, 0, 0, 0, 1);
        row(21, 1, 17, 1, 1, 0, 0);

        RSTn = 1'b0; i_start = 1'b0; i_x_data = '0; i_x_valid = 1'b0;
        i_layer_busy = 1'b0; i_y_stb = 1'b0; i_y_ack = 1'b0; i_w_data = '0;
        slow_beat = -1;
        clear_mon();
        repeat (2) @(negedge clk);

        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_stb", o_stb, 0);
        chk("rst_waddr", o_w_addr, 0);
        chk("rst_data", o_data, 0);
        chk("rst_en", {o_EN_w, o_EN_c, o_w_rd, o_x_ready}, 0);

        // Reset asserted while beat 2 is being offered
        RSTn = 1'b1;
        @(negedge clk);
        i_start = 1'b1; cyc(); i_start = 1'b0;
        for (int i = 0; i < 200 && !(n_wxfer == 2 && o_stb); i++) cyc();
        chk("midsend_reached", o_stb, 1);
        RSTn = 1'b0;
        #1;
        chk("midrst_stb", o_stb, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_enc", o_EN_c, 0);
        chk("midrst_waddr", o_w_addr, 0);
        chk("midrst_data", o_data, 0);
        @(negedge clk);
        RSTn = 1'b1;
        clear_mon();
        @(negedge clk);

        // Run 1: beat 3 stalled 5 cycles, CEN held off by layer busy
        slow_beat = 3;
        i_layer_busy = 1'b1;
        i_start = 1'b1; cyc(); i_start = 1'b0;
        for (int i = 0; i < 300 && n_wxfer < 8; i++) cyc();
        repeat (3) cyc();
        chk("cen_wait", o_EN_c, 0);
        chk("cen_busy", o_busy, 1);
        i_layer_busy = 1'b0;
        for (int i = 0; i < 5 && !o_EN_c; i++) cyc();
        chk("run1_enc", o_EN_c, 1);
        check_weights("run1");
        chk("hold103_cycles", n_hold103, 5);

        i_layer_busy = 1'b1;
        for (int i = 0; i < 22; i++) begin
            i_x_valid = tv[i].xv; i_x_data = tv[i].xd;
            i_y_stb = tv[i].ys; i_y_ack = tv[i].ya;
            eval();
            chk("tbl_rdy", o_x_ready, tv[i].exp_rdy);
            chk("tbl_enc", o_EN_c, tv[i].exp_enc);
            if (tv[i].exp_rdy) chk("tbl_data", o_data, tv[i].xd);
            if (!tv[i].exp_rdy && tv[i].xv) chk("tbl_nostb", o_stb, 0);
            @(negedge clk);
        end
        i_x_valid = 1'b0; i_y_stb = 1'b0; i_y_ack = 1'b0;
        chk("run1_nready", n_xrdy, 16);
        for (int k = 0; k < 16; k++) begin
            if (k < xq.size()) chk("run1_sample", xq[k], 32'(k + 1));
        end
        repeat (2) cyc();
        chk("run1_done_held", n_done, 0);
        i_layer_busy = 1'b0;
        for (int i = 0; i < 10 && n_done == 0; i++) cyc();
        repeat (3) cyc();
        chk("run1_ndone", n_done, 1);
        chk("run1_done_busy", done_busy, 1);
        chk("run1_idle", o_busy, 0);

        // Run 2: fresh load, start pulse during RUN, final sample and 7th output in the same cycle
        clear_mon();
        slow_beat = -1;
        i_start = 1'b1; cyc(); i_start = 1'b0;
        for (int i = 0; i < 300 && !o_EN_c; i++) cyc();
        chk("run2_enc", o_EN_c, 1);
        check_weights("run2");
        for (int i = 1; i <= 16; i++) begin
            i_x_valid = 1'b1;
            i_x_data  = 32'(200 + i);
            i_y_stb   = (i >= 4) && (i % 2 == 0);
            i_y_ack   = i_y_stb;
            i_start   = (i == 5);
            eval();
            chk("run2_rdy", o_x_ready, 1);
            @(negedge clk);
        end
        i_x_valid = 1'b0; i_y_stb = 1'b0; i_y_ack = 1'b0; i_start = 1'b0;
        eval();
        chk("run2_last_run", o_EN_c, 1);
        @(negedge clk);
        eval();
        chk("run2_fin_enc", o_EN_c, 0);
        chk("run2_fin_nodone", o_done, 0);
        @(negedge clk);
        eval();
        chk("run2_done", o_done, 1);
        chk("run2_done_busy", o_busy, 1);
        @(negedge clk);
        eval();
        chk("run2_after_done", o_done, 0);
        chk("run2_after_busy", o_busy, 0);
        @(negedge clk);
        chk("run2_nenw", n_enw, 1);
        chk("run2_nready", n_xrdy, 16);
        chk("run2_ndone", n_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_layer_seq.md
Name: cnn_layer_seq

Overview:
- Sequencer for one Conv1d+MaxPool layer instance, e.g. a 1-in/2-out channel layer with kernel 3 and pool 2.
- On a start pulse it reads biases and kernel weights from a 1-cycle-latency weight ROM and streams them to the layer's weight-load port.
- It then enables compute, forwards input samples from an upstream valid/ready source, and counts pooled outputs.
- It pulses done once the layer is idle. It sits between the top-level control FSM, the weight ROM and the layer.

Parameters:
- DW, 32, word width
- IN_CH, 1, input channels per beat
- OUT_CH, 2, output channels; must be a multiple of IN_CH
- SIZE_K, 3, kernel length
- N_SAMPLES, 16, input beats per inference
- N_OUT, 7, pooled output beats expected per inference
- AW, 8, weight ROM address width

Ports:
- clk  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start request; ignored while o_busy=1
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle completion pulse
- o_w_addr  out  AW  weight ROM address
- o_w_rd  out  1  ROM read strobe; data is valid on i_w_data the next cycle
- i_w_data  in  DW*IN_CH  ROM read data
- i_x_data  in  DW*IN_CH  input sample
- i_x_valid  in  1  input sample valid
- o_x_ready  out  1  input sample consumed this cycle
- o_EN_w  out  1  layer weight-load enable (pulse)
- o_EN_c  out  1  layer compute enable (level)
- i_layer_busy  in  1  layer busy
- o_data  out  DW*IN_CH  data to layer i_data
- o_stb  out  1  strobe to layer i_stb_in
- i_ack  in  1  layer o_ack_in
- i_y_stb  in  1  layer o_stb_out (monitored)
- i_y_ack  in  1  downstream ack of layer output (monitored)

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including o_data=0 and o_w_addr=0.
  - Counters 0.
- Transfer rule: a beat transfers on a rising edge where o_stb&&i_ack=1.
  - o_data is stable while o_stb=1.
  - o_stb drops the cycle after the transfer.
- Weight-load beat count: NB = OUT_CH/IN_CH + SIZE_K*OUT_CH (8 with defaults).
  - ROM addresses run 0..NB-1: biases first, then kernel taps in output-channel-major order.
- States:
  - IDLE: when i_start=1, go to WEN and clear the address counter.
  - WEN: o_EN_w=1 for exactly 1 cycle, then go to RD.
  - RD: o_w_rd=1 and o_w_addr=addr for 1 cycle, then go to WAIT.
  - WAIT: register i_w_data into o_data, then go to SEND.
  - SEND: o_stb=1 until i_ack.
    - On transfer with addr==NB-1, go to CEN.
    - Otherwise increment addr and go to RD.
  - CEN: wait until i_layer_busy=0, then go to RUN.
  - RUN:
    - o_EN_c=1.
    - o_data=i_x_data (combinational mux).
    - o_stb=i_x_valid && (sent<N_SAMPLES).
    - o_x_ready=o_stb&&i_ack.
    - sent increments per transfer.
    - got increments on each i_y_stb&&i_y_ack; a simultaneous sample transfer and output handshake both count.
    - When got==N_OUT and sent==N_SAMPLES, go to FIN.
  - FIN: o_EN_c=0; wait until i_layer_busy=0, then pulse o_done for 1 cycle and go to IDLE.
- Latency:
  - Minimum 3 cycles per weight beat.
  - Weight phase minimum is 1+3*NB cycles after start (25 cycles with defaults).
- o_busy=1 in every state except IDLE.
  - o_done is asserted in the FIN->IDLE transition cycle, while o_busy is still 1.
- Boundary conditions:
  - i_start while busy: ignored, no restart.
  - i_x_valid=1 with sent==N_SAMPLES: no strobe, o_x_ready=0.
  - Extra output handshakes after got==N_OUT: got saturates.
  - Reset mid-operation returns to IDLE asynchronously, with all outputs and counters at their reset values.
  - i_ack without o_stb: ignored.
- Arithmetic: sent and got counters are $clog2(max)+1 bits wide and unsigned.

Test Plan:
- Reset: assert RSTn=0 mid-SEND -> next cycle o_stb=0, o_busy=0, o_EN_c=0, o_w_addr=0.
- Weight load with defaults, ROM[a]=a+100, layer model acks 1 cycle after strobe.
  - o_EN_w pulses exactly once.
  - The layer receives 100..107 in order with no duplicates.
  - o_w_rd asserts 8 times.
- Ack delayed 5 cycles on beat 3 -> o_data holds 103 stable with o_stb=1 for all 5 cycles; exactly 8 transfers total.
- Compute: 16 samples 1..16 with i_x_valid gaps, 7 output handshakes.
  - Exactly 16 o_x_ready pulses.
  - A 17th valid sample is not consumed.
  - o_done pulses once, after i_layer_busy falls.
- i_start pulsed during RUN -> no effect on counters or state; a later i_start in IDLE starts a fresh load from addr 0.
- Sample transfer and output handshake in the same cycle -> both sent and got increment; done timing is correct.
